// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every requester-side and memory-side signal of the shared
//   main-memory arbiter.
//   master : arbiter view (requests/addresses/mem responses in, pulses/data/mem request out)
//   slave  : environment view (requesters, write buffer and memory model)
//   Signals: ic_* I-cache refill, dc_* D-cache refill, wb_* write-buffer drain,
//            mem_* main-memory port, busy = arbiter not idle.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  ic_req;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  ic_rvalid;
    logic [LINE_WIDTH-1:0] ic_rdata;
    logic                  dc_req;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic                  dc_rvalid;
    logic [LINE_WIDTH-1:0] dc_rdata;
    logic                  wb_req;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [LINE_WIDTH-1:0] wb_wdata;
    logic                  wb_full;
    logic                  wb_ack;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_addr,
        input  wb_req, wb_addr, wb_wdata, wb_full,
        input  mem_ack, mem_rdata,
        output ic_rvalid, ic_rdata, dc_rvalid, dc_rdata, wb_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_addr,
        output wb_req, wb_addr, wb_wdata, wb_full,
        output mem_ack, mem_rdata,
        input  ic_rvalid, ic_rdata, dc_rvalid, dc_rdata, wb_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Sequences one shared main-memory port between I-cache refills, D-cache
//   refills and write-buffer drains. Reads are preferred (round-robin between
//   the caches) unless the write buffer is full, a write has been passed over
//   STARVE_MAX times, or a pending read hits the line being drained.
//   Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.master).
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4,
    parameter int STARVE_MAX  = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_WB} owner_t;

    state_t                r_state;
    state_t                w_next;
    owner_t                r_owner;
    owner_t                w_grant;
    logic                  r_rr_dc;     // 1: D-cache wins the next read tie
    logic [CNT_W-1:0]      r_starve;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_ic_rdata;
    logic [LINE_WIDTH-1:0] r_dc_rdata;

    logic                  w_any_req;
    logic                  w_both_rd;
    logic                  w_ic_raw;
    logic                  w_dc_raw;
    logic                  w_force_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;

    assign w_any_req = bus.ic_req | bus.dc_req | bus.wb_req;
    assign w_both_rd = bus.ic_req & bus.dc_req;

    // A read of the line still sitting in the write buffer must see the new data.
    assign w_ic_raw = bus.ic_req &&
        (bus.ic_addr[ADDR_WIDTH-1:OFFSET_BITS] == bus.wb_addr[ADDR_WIDTH-1:OFFSET_BITS]);
    assign w_dc_raw = bus.dc_req &&
        (bus.dc_addr[ADDR_WIDTH-1:OFFSET_BITS] == bus.wb_addr[ADDR_WIDTH-1:OFFSET_BITS]);
    assign w_force_wr = bus.wb_req &&
        (bus.wb_full || (r_starve == CNT_W'(STARVE_MAX)) || w_ic_raw || w_dc_raw);

    always_comb begin
        w_grant = OWN_WB;
        if (w_force_wr)
            w_grant = OWN_WB;
        else if (w_both_rd)
            w_grant = r_rr_dc ? OWN_DC : OWN_IC;
        else if (bus.ic_req)
            w_grant = OWN_IC;
        else if (bus.dc_req)
            w_grant = OWN_DC;
    end

    always_comb begin
        w_sel_addr = bus.wb_addr;
        case (w_grant)
            OWN_IC:  w_sel_addr = bus.ic_addr;
            OWN_DC:  w_sel_addr = bus.dc_addr;
            default: w_sel_addr = bus.wb_addr;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_WAIT;
            S_WAIT:  if (bus.mem_ack) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_IC;
            r_rr_dc    <= 1'b1;
            r_starve   <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ic_rdata <= '0;
            r_dc_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_grant;
                r_we    <= (w_grant == OWN_WB);
                r_addr  <= {w_sel_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (w_grant == OWN_WB) begin
                    r_wdata  <= bus.wb_wdata;
                    r_starve <= '0;
                end else if (bus.wb_req && r_starve != CNT_W'(STARVE_MAX)) begin
                    r_starve <= r_starve + CNT_W'(1);
                end
                // Round-robin only advances when the tie actually decided a read grant.
                if (w_both_rd && !w_force_wr)
                    r_rr_dc <= ~r_rr_dc;
            end
            if (r_state == S_WAIT && bus.mem_ack) begin
                if (r_owner == OWN_IC) r_ic_rdata <= bus.mem_rdata;
                if (r_owner == OWN_DC) r_dc_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = (r_state == S_WAIT);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.ic_rvalid = (r_state == S_RESP) && (r_owner == OWN_IC);
    assign bus.dc_rvalid = (r_state == S_RESP) && (r_owner == OWN_DC);
    assign bus.wb_ack    = (r_state == S_RESP) && (r_owner == OWN_WB);
    assign bus.ic_rdata  = r_ic_rdata;
    assign bus.dc_rdata  = r_dc_rdata;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives the arbiter through directed scenarios and a randomized phase;
//   a transaction-level model predicts each grant, address and returned line.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int OB   = 4;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) ifc();

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(OB), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: round-robin preference, starvation count, last refill lines.
    logic          m_rr_dc;
    int            m_starve;
    logic [LW-1:0] m_icd;
    logic [LW-1:0] m_dcd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic same_line(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> OB) == (b >> OB);
    endfunction

    // 0 = I-cache, 1 = D-cache, 2 = write buffer
    function automatic int model_owner();
        logic raw;
        raw = (ifc.ic_req && same_line(ifc.ic_addr, ifc.wb_addr)) ||
              (ifc.dc_req && same_line(ifc.dc_addr, ifc.wb_addr));
        if (ifc.wb_req && (ifc.wb_full || m_starve == SMAX || raw)) return 2;
        if (ifc.ic_req && ifc.dc_req) return m_rr_dc ? 1 : 0;
        if (ifc.ic_req) return 0;
        if (ifc.dc_req) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_rr_dc  = 1'b1;
        m_starve = 0;
        m_icd    = '0;
        m_dcd    = '0;
    endtask

    task automatic clear_reqs();
        ifc.ic_req  = 1'b0;
        ifc.dc_req  = 1'b0;
        ifc.wb_req  = 1'b0;
        ifc.wb_full = 1'b0;
    endtask

    // One full transaction from an IDLE cycle with at least one request pending.
    // Returns the owner observed from the response pulse (3 = none).
    task automatic txn(input int k, output int own);
        int            exp;
        logic [AW-1:0] ea;
        logic [LW-1:0] ew;
        logic [LW-1:0] rd;
        exp = model_owner();
        ea  = (exp == 0) ? ifc.ic_addr : (exp == 1) ? ifc.dc_addr : ifc.wb_addr;
        ea  = (ea >> OB) << OB;
        ew  = ifc.wb_wdata;
        if (ifc.ic_req && ifc.dc_req && exp != 2) m_rr_dc = ~m_rr_dc;
        if (exp == 2) m_starve = 0;
        else if (ifc.wb_req && m_starve < SMAX) m_starve++;
        tick();
        chk("mem_req_c1", ifc.mem_req, 1'b1);
        chk("busy_c1", ifc.busy, 1'b1);
        chk("mem_we", ifc.mem_we, exp == 2);
        chk("mem_addr", ifc.mem_addr, ea);
        if (exp == 2) chk("mem_wdata", ifc.mem_wdata, ew);
        for (int i = 0; i < k; i++) begin
            // Owner's inputs move after grant; the latched request must not.
            if (exp == 0) ifc.ic_addr = $urandom();
            if (exp == 1) ifc.dc_addr = $urandom();
            if (exp == 2) begin
                ifc.wb_addr  = $urandom();
                ifc.wb_wdata = rand_line();
            end
            tick();
            chk("mem_req_hold", ifc.mem_req, 1'b1);
            chk("mem_addr_hold", ifc.mem_addr, ea);
            if (exp == 2) chk("mem_wdata_hold", ifc.mem_wdata, ew);
        end
        rd            = rand_line();
        ifc.mem_rdata = rd;
        ifc.mem_ack   = 1'b1;
        tick();
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = rand_line();
        if (exp == 0) m_icd = rd;
        if (exp == 1) m_dcd = rd;
        own = ifc.ic_rvalid ? 0 : ifc.dc_rvalid ? 1 : ifc.wb_ack ? 2 : 3;
        chk("owner", own, exp);
        chk("ic_rvalid", ifc.ic_rvalid, exp == 0);
        chk("dc_rvalid", ifc.dc_rvalid, exp == 1);
        chk("wb_ack", ifc.wb_ack, exp == 2);
        chk("mem_req_resp", ifc.mem_req, 1'b0);
        chk("ic_rdata", ifc.ic_rdata, m_icd);
        chk("dc_rdata", ifc.dc_rdata, m_dcd);
        if (exp == 0) ifc.ic_req = 1'b0;
        if (exp == 1) ifc.dc_req = 1'b0;
        if (exp == 2) begin
            ifc.wb_req  = 1'b0;
            ifc.wb_full = 1'b0;
        end
        tick();
        chk("busy_idle", ifc.busy, 1'b0);
        chk("no_pulse_idle", {ifc.ic_rvalid, ifc.dc_rvalid, ifc.wb_ack}, 3'b000);
    endtask

    initial begin
        int own;
        int seq[$];
        ifc.ic_req = 0; ifc.ic_addr = 0; ifc.dc_req = 0; ifc.dc_addr = 0;
        ifc.wb_req = 0; ifc.wb_addr = 0; ifc.wb_wdata = 0; ifc.wb_full = 0;
        ifc.mem_ack = 0; ifc.mem_rdata = 0;
        model_reset();

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_mem_req", ifc.mem_req, 1'b0);
        chk("rst_mem_we", ifc.mem_we, 1'b0);
        chk("rst_mem_addr", ifc.mem_addr, '0);
        chk("rst_mem_wdata", ifc.mem_wdata, '0);
        chk("rst_ic_rdata", ifc.ic_rdata, '0);
        chk("rst_dc_rdata", ifc.dc_rdata, '0);
        chk("rst_pulses", {ifc.ic_rvalid, ifc.dc_rvalid, ifc.wb_ack}, 3'b000);
        chk("rst_busy", ifc.busy, 1'b0);

        // Single D-cache refill, ack one cycle after mem_req
        ifc.dc_req = 1'b1; ifc.dc_addr = 32'h0000_0014;
        txn(1, own);
        chk("single_dc_owner", own, 1);
        chk("single_dc_addr_line", dut.bus.mem_addr, 32'h0000_0010);

        // Both caches held: D, I, D, I
        seq.delete();
        ifc.ic_addr = 32'h0000_0100; ifc.dc_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            ifc.ic_req = 1'b1; ifc.dc_req = 1'b1;
            txn($urandom_range(1, 3), own);
            seq.push_back(own);
        end
        clear_reqs();
        chk("rr_0", seq[0], 1);
        chk("rr_1", seq[1], 0);
        chk("rr_2", seq[2], 1);
        chk("rr_3", seq[3], 0);

        // Starvation: four reads pass the write, then the write is forced
        seq.delete();
        ifc.wb_req = 1'b1; ifc.wb_addr = 32'h0000_8000; ifc.wb_wdata = rand_line();
        for (int i = 0; i < 5; i++) begin
            ifc.dc_req = 1'b1; ifc.dc_addr = 32'h0000_0400;
            txn(1, own);
            seq.push_back(own);
        end
        clear_reqs();
        for (int i = 0; i < 4; i++) chk($sformatf("starve_rd%0d", i), seq[i], 1);
        chk("starve_wr", seq[4], 2);

        // Read hits the draining line: write first, then the read
        ifc.dc_req = 1'b1; ifc.dc_addr = 32'h0000_1234;
        ifc.wb_req = 1'b1; ifc.wb_addr = 32'h0000_1238; ifc.wb_wdata = rand_line();
        txn(2, own);
        chk("raw_first", own, 2);
        txn(1, own);
        chk("raw_second", own, 1);
        clear_reqs();

        // Full buffer beats a pending I-cache read
        ifc.ic_req = 1'b1; ifc.ic_addr = 32'h0000_2000;
        ifc.wb_req = 1'b1; ifc.wb_addr = 32'h0000_3000; ifc.wb_full = 1'b1;
        ifc.wb_wdata = rand_line();
        txn(1, own);
        chk("full_first", own, 2);
        txn(1, own);
        chk("full_second", own, 0);
        clear_reqs();

        // Slow memory: request held stable for ten cycles
        ifc.dc_req = 1'b1; ifc.dc_addr = 32'h0000_5678;
        txn(10, own);
        chk("slow_owner", own, 1);
        clear_reqs();

        // Stray mem_ack while idle does nothing
        ifc.mem_ack = 1'b1;
        tick();
        ifc.mem_ack = 1'b0;
        chk("stray_ack_busy", ifc.busy, 1'b0);
        tick();
        chk("stray_ack_pulses", {ifc.ic_rvalid, ifc.dc_rvalid, ifc.wb_ack}, 3'b000);

        // Reset while waiting on memory abandons the transaction
        ifc.dc_req = 1'b1; ifc.dc_addr = 32'h0000_7770;
        tick();
        tick();
        chk("pre_rst_mem_req", ifc.mem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.dc_req = 1'b0;
        model_reset();
        chk("mid_rst_mem_req", ifc.mem_req, 1'b0);
        chk("mid_rst_busy", ifc.busy, 1'b0);
        chk("mid_rst_dc_rdata", ifc.dc_rdata, '0);
        ifc.mem_ack = 1'b1;
        tick();
        ifc.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_pulse", {ifc.ic_rvalid, ifc.dc_rvalid, ifc.wb_ack}, 3'b000);
            tick();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            if (!ifc.wb_req && $urandom_range(0, 1) == 1) begin
                ifc.wb_req   = 1'b1;
                ifc.wb_addr  = $urandom();
                ifc.wb_wdata = rand_line();
            end
            if (!ifc.ic_req && $urandom_range(0, 1) == 1) begin
                ifc.ic_req  = 1'b1;
                ifc.ic_addr = ($urandom_range(0, 3) == 0) ? (ifc.wb_addr ^ AW'($urandom_range(0, 15)))
                                                         : $urandom();
            end
            if (!ifc.dc_req && $urandom_range(0, 1) == 1) begin
                ifc.dc_req  = 1'b1;
                ifc.dc_addr = ($urandom_range(0, 3) == 0) ? (ifc.wb_addr ^ AW'($urandom_range(0, 15)))
                                                         : $urandom();
            end
            ifc.wb_full = ifc.wb_req && ($urandom_range(0, 4) == 0);
            if (!ifc.ic_req && !ifc.dc_req && !ifc.wb_req) begin
                ifc.dc_req  = 1'b1;
                ifc.dc_addr = $urandom();
            end
            txn($urandom_range(1, 4), own);
        end
        clear_reqs();
        tick();
        chk("final_idle", ifc.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
